grad_denorm: RTL and testbench

GRAD_DENORM -- requirements
Module: grad_denorm

---
 rtl/grad_norm_pkg.sv | 24 ++
 rtl/grad_fwd_model.sv | 29 ++
 rtl/grad_denorm.sv | 119 +++++++++++
 tb/tb_grad_denorm.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_norm_pkg.sv
// Shared tables and types for gradient denormalisation: forward-model breakpoints,
// per-segment shift amounts, default widths and FSM state encoding.
package grad_norm_pkg;

  localparam int IN_W_DEF        = 11;
  localparam int OUT_W_DEF       = 12;
  localparam int SEARCH_BITS_DEF = 9;
  localparam int NSEG            = 8;
  localparam int PROD_W          = 19;

  localparam logic [10:0] BP_G [0:8] = '{11'd0, 11'd4, 11'd8, 11'd16, 11'd32,
                                         11'd64, 11'd128, 11'd192, 11'd256};
  localparam logic [10:0] BP_Y [0:8] = '{11'd1024, 11'd912, 11'd816, 11'd640, 11'd448,
                                         11'd256, 11'd64, 11'd16, 11'd0};
  // log2 of each segment width, so segment interpolation needs no divider
  localparam int SEG_SH [0:7] = '{2, 2, 3, 4, 5, 6, 6, 6};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/grad_fwd_model.sv
// Combinational forward model f(g): piecewise-linear, non-increasing, zero for g >= 256.
// Zero latency; no handshake.
module grad_fwd_model
  import grad_norm_pkg::*;
#(
  parameter int G_W = SEARCH_BITS_DEF,
  parameter int F_W = IN_W_DEF
) (
  input  logic [G_W-1:0] i_g,
  output logic [F_W-1:0] o_f
);

  logic [PROD_W-1:0] w_g;
  logic [PROD_W-1:0] w_prod;

  assign w_g = PROD_W'(i_g);

  always_comb begin
    o_f    = '0;
    w_prod = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (w_g >= PROD_W'(BP_G[k]) && w_g < PROD_W'(BP_G[k+1])) begin
        w_prod = (PROD_W'(BP_Y[k]) - PROD_W'(BP_Y[k+1])) * (w_g - PROD_W'(BP_G[k]));
        o_f    = F_W'(PROD_W'(BP_Y[k]) - (w_prod >> SEG_SH[k]));
      end
    end
  end

endmodule

// File: rtl/grad_denorm.sv
// Recovers g = min{g : f(g) <= n} by a SEARCH_BITS-step successive approximation; result 10 cycles after accept.
// Result held until out_ready; in_ready low until taken. GRAD_DENORM_FASTPATH_EN: n==0 / n>=1024 answered next cycle.
module grad_denorm
  import grad_norm_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int SEARCH_BITS = SEARCH_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  norm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] grad_out,
  output logic             busy
);

  localparam int BIT_W = (SEARCH_BITS > 1) ? $clog2(SEARCH_BITS) : 1;

  state_t                 r_state;
  logic [SEARCH_BITS-1:0] r_acc;
  logic [IN_W-1:0]        r_n;
  logic [BIT_W-1:0]       r_bit;
  logic [OUT_W-1:0]       r_grad;
  logic                   r_out_valid;
  logic                   r_in_ready;
  logic                   r_busy;

  logic [SEARCH_BITS-1:0] w_t;
  logic [IN_W-1:0]        w_f;
  logic [SEARCH_BITS-1:0] w_acc_nxt;
  logic                   w_f0_le;
  logic [OUT_W-1:0]       w_result;

  assign w_t       = r_acc | (SEARCH_BITS'(1) << r_bit);
  assign w_acc_nxt = (w_f > r_n) ? w_t : r_acc;
  assign w_f0_le   = r_n >= IN_W'(BP_Y[0]);
  assign w_result  = w_f0_le ? '0 : OUT_W'(w_acc_nxt) + OUT_W'(1);

  grad_fwd_model #(
    .G_W (SEARCH_BITS),
    .F_W (IN_W)
  ) u_fwd (
    .i_g (w_t),
    .o_f (w_f)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_n         <= '0;
      r_bit       <= '0;
      r_grad      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_n        <= norm_in;
            r_acc      <= '0;
            r_bit      <= BIT_W'(SEARCH_BITS - 1);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef GRAD_DENORM_FASTPATH_EN
            if (norm_in >= IN_W'(BP_Y[0])) begin
              r_grad      <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else if (norm_in == '0) begin
              r_grad      <= OUT_W'(BP_G[NSEG]);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_SEARCH;
            end
`else
            r_state <= ST_SEARCH;
`endif
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_SEARCH: begin
          r_acc <= w_acc_nxt;
          if (r_bit == '0) begin
            r_grad      <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_bit <= r_bit - BIT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign grad_out  = r_grad;
  assign busy      = r_busy;

endmodule

// File: tb/tb_grad_denorm.sv
// Scoreboarded bench for grad_denorm: directed vectors, hold/backpressure, reset abort, random stream.
module tb_grad_denorm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] norm_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] grad_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  localparam int LAT_FULL = 10;
`ifdef GRAD_DENORM_FASTPATH_EN
  localparam int LAT_EXT = 1;
`else
  localparam int LAT_EXT = 10;
`endif

  grad_denorm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .norm_in   (norm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_f(input int g);
    int gt[9] = '{0, 4, 8, 16, 32, 64, 128, 192, 256};
    int yt[9] = '{1024, 912, 816, 640, 448, 256, 64, 16, 0};
    for (int k = 0; k < 8; k++)
      if (g >= gt[k] && g < gt[k+1])
        return yt[k] - ((yt[k] - yt[k+1]) * (g - gt[k])) / (gt[k+1] - gt[k]);
    return 0;
  endfunction

  function automatic int ref_grad(input int n);
    for (int g = 0; g <= 256; g++)
      if (ref_f(g) <= n) return g;
    return 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s: in_ready timeout, got %0b want 1", name, in_ready);
    end
  endtask

  // Single transaction: accept, measure latency, score result, then take it.
  task automatic do_txn(input int n, input int exp_lat, input string name);
    int lat;
    int e;
    wait_ready(name);
    in_valid = 1'b1;
    norm_in  = 11'(n);
    exp_q.push_back(ref_grad(n));
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: out_valid timeout, got %0b want 1", name, out_valid);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (grad_out !== 12'(e)) begin
        errors++;
        $display("FAIL %s: grad_out got %0d want %0d (n=%0d)", name, grad_out, e, n);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #20;
    checks++;
    if ({in_ready, out_valid, busy, grad_out} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b busy=%0b grad=%0d want all 0",
               in_ready, out_valid, busy, grad_out);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy: got %0b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_after: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    do_txn(1023, LAT_FULL, "n1023");
    do_txn(512,  LAT_FULL, "n512");
    do_txn(256,  LAT_FULL, "n256");
    do_txn(0,    LAT_EXT,  "n0");
    do_txn(1024, LAT_EXT,  "n1024");
    do_txn(2047, LAT_EXT,  "n2047");
    do_txn(1,    LAT_FULL, "n1");
  endtask

  // in_valid left high with a different value during SEARCH/DONE; output held under backpressure.
  task automatic test_hold();
    int k = 0;
    logic [11:0] first;
    wait_ready("hold");
    in_valid = 1'b1;
    norm_in  = 11'd512;
    tick();
    norm_in = 11'd5;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy: got %0b want 1", busy);
    end
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    first = grad_out;
    checks++;
    if (!out_valid || first !== 12'd27) begin
      errors++;
      $display("FAIL hold_result: got vld=%0b grad=%0d want vld=1 grad=27", out_valid, first);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || grad_out !== first || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: got vld=%0b grad=%0d rdy=%0b want 1/%0d/0",
                 out_valid, grad_out, in_ready, first);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got vld=%0b busy=%0b rdy=%0b want 0/0/1", out_valid, busy, in_ready);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_extra: got vld=%0b busy=%0b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    wait_ready("abort");
    in_valid = 1'b1;
    norm_in  = 11'd100;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, grad_out} !== 15'd0) begin
      errors++;
      $display("FAIL abort_outputs: got rdy=%0b vld=%0b busy=%0b grad=%0d want all 0",
               in_ready, out_valid, busy, grad_out);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    do_txn(640, LAT_FULL, "after_abort");
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int cyc;
    fork
      begin : driver
        int k = 0;
        while (sent < 60 && k < 5000) begin
          if (in_ready) begin
            int n;
            n = $urandom_range(0, 2047);
            in_valid = 1'b1;
            norm_in  = 11'(n);
            exp_q.push_back(ref_grad(n));
            sent++;
          end
          tick();
          in_valid = 1'b0;
          k++;
        end
      end
      begin : receiver
        cyc = 0;
        while (got < 60 && cyc < 5000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            int e;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_unexpected: got grad=%0d want no output", grad_out);
            end else begin
              e = exp_q.pop_front();
              if (grad_out !== 12'(e)) begin
                errors++;
                $display("FAIL rand_result %0d: got %0d want %0d", got, grad_out, e);
              end
            end
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (got !== 60 || sent !== 60) begin
      errors++;
      $display("FAIL rand_count: got sent=%0d recv=%0d want 60/60", sent, got);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
